// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control path: opcodes, ALU encodings,
// sequencer step states and the datapath strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned ALU_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OPCODE_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0011;

  typedef enum logic [3:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } step_e;

  typedef struct packed {
    logic pci;
    logic pco;
    logic pc_inc;
    logic iri;
    logic mari;
    logic mdri;
    logic mdro;
    logic ryi;
    logic zi;
    logic zlowo;
    logic csigno;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baout;
    logic ipo;
    logic opi;
    logic con_in;
    logic mem_read;
    logic mem_write;
  } strobes_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts MEM_LAT enabled cycles of a memory access and flags the final one.
module mem_wait_counter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic done_c_o
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_c_o = en_i && (cnt_q == CNT_W'(MEM_LAT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (done_c_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired fetch/decode/execute sequencer driving all Mini SRC datapath strobes
// from the step state, the latched opcode and con_ff.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir,
  input  logic             con_ff,
  input  logic             stop,
  output logic             pci,
  output logic             pco,
  output logic             pc_inc,
  output logic             iri,
  output logic             mari,
  output logic             mdri,
  output logic             mdro,
  output logic             ryi,
  output logic             zi,
  output logic             zlowo,
  output logic             csigno,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             rin,
  output logic             rout,
  output logic             baout,
  output logic             ipo,
  output logic             opi,
  output logic             con_in,
  output logic             mem_read,
  output logic             mem_write,
  output logic [ALU_W-1:0] alu_op,
  output logic             run,
  output logic             illegal
);

  step_e                state_q, state_d;
  logic [OPCODE_W-1:0]  opcode_q, opcode_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [OPCODE_W-1:0]  op_in;
  strobes_t             strb_c, out_c;
  logic [ALU_W-1:0]     alu_c;
  logic                 illegal_c, wait_en_c, wait_done_c, last_c;
  logic                 unused_ir_c;

  assign op_in       = ir[31 -: OPCODE_W];
  assign unused_ir_c = ^ir[31-OPCODE_W:0];

  mem_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk_i    (clock),
    .rst_i    (clear),
    .en_i     (wait_en_c),
    .done_c_o (wait_done_c)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= ST_T0;
      opcode_q    <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    stop_pend_d = stop_pend_q | stop;
    strb_c      = '0;
    alu_c       = ALU_ADD;
    illegal_c   = 1'b0;
    wait_en_c   = 1'b0;
    last_c      = 1'b0;
    unique case (state_q)
      ST_T0: begin
        strb_c.pco = 1'b1; strb_c.mari = 1'b1; strb_c.pc_inc = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        strb_c.mem_read = 1'b1; wait_en_c = 1'b1; strb_c.mdri = wait_done_c;
        if (wait_done_c) state_d = ST_T2;
      end
      ST_T2: begin
        strb_c.mdro = 1'b1; strb_c.iri = 1'b1;
        opcode_d = op_in;
        if (op_in == OP_HALT)     state_d = ST_HALT;
        else if (op_in == OP_NOP) last_c  = 1'b1;
        else                      state_d = ST_T3;
      end
      ST_T3: begin
        state_d = ST_T4;
        unique case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            strb_c.grb = 1'b1; strb_c.rout = 1'b1; strb_c.ryi = 1'b1;
          end
          OP_LDI, OP_LD, OP_ST: begin
            strb_c.grb = 1'b1; strb_c.baout = 1'b1; strb_c.ryi = 1'b1;
          end
          OP_BR: begin
            strb_c.gra = 1'b1; strb_c.rout = 1'b1; strb_c.con_in = 1'b1;
          end
          OP_IN: begin
            strb_c.ipo = 1'b1; strb_c.gra = 1'b1; strb_c.rin = 1'b1; last_c = 1'b1;
          end
          OP_OUT: begin
            strb_c.gra = 1'b1; strb_c.rout = 1'b1; strb_c.opi = 1'b1; last_c = 1'b1;
          end
          // undefined opcode: one flagged dead cycle, then behaves as nop
          default: begin
            illegal_c = 1'b1; last_c = 1'b1;
          end
        endcase
      end
      ST_T4: begin
        state_d = ST_T5;
        unique case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            strb_c.grc = 1'b1; strb_c.rout = 1'b1; strb_c.zi = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
            strb_c.csigno = 1'b1; strb_c.zi = 1'b1;
          end
          OP_BR: begin
            strb_c.pco = 1'b1; strb_c.ryi = 1'b1;
          end
          default: last_c = 1'b1;
        endcase
        unique case (opcode_q)
          OP_SUB:          alu_c = ALU_SUB;
          OP_AND, OP_ANDI: alu_c = ALU_AND;
          OP_OR,  OP_ORI:  alu_c = ALU_OR;
          default:         alu_c = ALU_ADD;
        endcase
      end
      ST_T5: begin
        state_d = ST_T6;
        unique case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            strb_c.zlowo = 1'b1; strb_c.gra = 1'b1; strb_c.rin = 1'b1; last_c = 1'b1;
          end
          OP_LD, OP_ST: begin
            strb_c.zlowo = 1'b1; strb_c.mari = 1'b1;
          end
          OP_BR: begin
            strb_c.csigno = 1'b1; strb_c.zi = 1'b1;
          end
          default: last_c = 1'b1;
        endcase
      end
      ST_T6: begin
        unique case (opcode_q)
          OP_LD: begin
            strb_c.mem_read = 1'b1; wait_en_c = 1'b1; strb_c.mdri = wait_done_c;
            if (wait_done_c) state_d = ST_T7;
          end
          OP_ST: begin
            strb_c.gra = 1'b1; strb_c.rout = 1'b1; strb_c.mdri = 1'b1;
            state_d = ST_T7;
          end
          OP_BR: begin
            strb_c.zlowo = 1'b1; strb_c.pci = con_ff; last_c = 1'b1;
          end
          default: last_c = 1'b1;
        endcase
      end
      ST_T7: begin
        unique case (opcode_q)
          OP_LD: begin
            strb_c.mdro = 1'b1; strb_c.gra = 1'b1; strb_c.rin = 1'b1; last_c = 1'b1;
          end
          OP_ST: begin
            strb_c.mem_write = 1'b1; wait_en_c = 1'b1; last_c = wait_done_c;
          end
          default: last_c = 1'b1;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T0;
    endcase
    // a pending or current stop request turns the instruction boundary into HALT
    if (last_c) begin
      state_d     = (stop || stop_pend_q) ? ST_HALT : ST_T0;
      stop_pend_d = 1'b0;
    end
  end

  assign out_c     = clear ? '0 : strb_c;
  assign alu_op    = clear ? '0 : alu_c;
  assign illegal   = ~clear & illegal_c;
  assign run       = (state_q != ST_HALT);

  assign pci       = out_c.pci;
  assign pco       = out_c.pco;
  assign pc_inc    = out_c.pc_inc;
  assign iri       = out_c.iri;
  assign mari      = out_c.mari;
  assign mdri      = out_c.mdri;
  assign mdro      = out_c.mdro;
  assign ryi       = out_c.ryi;
  assign zi        = out_c.zi;
  assign zlowo     = out_c.zlowo;
  assign csigno    = out_c.csigno;
  assign gra       = out_c.gra;
  assign grb       = out_c.grb;
  assign grc       = out_c.grc;
  assign rin       = out_c.rin;
  assign rout      = out_c.rout;
  assign baout     = out_c.baout;
  assign ipo       = out_c.ipo;
  assign opi       = out_c.opi;
  assign con_in    = out_c.con_in;
  assign mem_read  = out_c.mem_read;
  assign mem_write = out_c.mem_write;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: two sequencers (MEM_LAT 1 and 3) run directed and random
// instruction streams against an instruction-level model of the strobe sequences.
module tb_control_sequencer;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;
  localparam int unsigned VW   = 28;
  typedef logic [VW-1:0] vec_t;

  localparam vec_t M_PCI   = vec_t'(1) << 0;
  localparam vec_t M_PCO   = vec_t'(1) << 1;
  localparam vec_t M_PCINC = vec_t'(1) << 2;
  localparam vec_t M_IRI   = vec_t'(1) << 3;
  localparam vec_t M_MARI  = vec_t'(1) << 4;
  localparam vec_t M_MDRI  = vec_t'(1) << 5;
  localparam vec_t M_MDRO  = vec_t'(1) << 6;
  localparam vec_t M_RYI   = vec_t'(1) << 7;
  localparam vec_t M_ZI    = vec_t'(1) << 8;
  localparam vec_t M_ZLOWO = vec_t'(1) << 9;
  localparam vec_t M_CSIGN = vec_t'(1) << 10;
  localparam vec_t M_GRA   = vec_t'(1) << 11;
  localparam vec_t M_GRB   = vec_t'(1) << 12;
  localparam vec_t M_GRC   = vec_t'(1) << 13;
  localparam vec_t M_RIN   = vec_t'(1) << 14;
  localparam vec_t M_ROUT  = vec_t'(1) << 15;
  localparam vec_t M_BAOUT = vec_t'(1) << 16;
  localparam vec_t M_IPO   = vec_t'(1) << 17;
  localparam vec_t M_OPI   = vec_t'(1) << 18;
  localparam vec_t M_CONIN = vec_t'(1) << 19;
  localparam vec_t M_MRD   = vec_t'(1) << 20;
  localparam vec_t M_MWR   = vec_t'(1) << 21;
  localparam vec_t M_RUN   = vec_t'(1) << 22;
  localparam vec_t M_ILL   = vec_t'(1) << 23;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] ir_r [2];
  logic [1:0]  cff_r, stop_r;
  logic [1:0]  pci_w, pco_w, pcinc_w, iri_w, mari_w, mdri_w, mdro_w, ryi_w, zi_w;
  logic [1:0]  zlowo_w, csign_w, gra_w, grb_w, grc_w, rin_w, rout_w, baout_w;
  logic [1:0]  ipo_w, opi_w, conin_w, mrd_w, mwr_w, run_w, ill_w;
  logic [3:0]  alu_w [2];

  vec_t q0[$];
  vec_t q1[$];
  logic [1:0] chk;
  int vectors = 0;
  int fails   = 0;

  logic [4:0] ops [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6,
                           5'd12, 5'd13, 5'd14, 5'd18, 5'd22, 5'd23, 5'd26};

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    control_sequencer #(.MEM_LAT((g == 0) ? LAT0 : LAT1)) u_dut (
      .clock(clock), .clear(clear), .ir(ir_r[g]), .con_ff(cff_r[g]), .stop(stop_r[g]),
      .pci(pci_w[g]), .pco(pco_w[g]), .pc_inc(pcinc_w[g]), .iri(iri_w[g]),
      .mari(mari_w[g]), .mdri(mdri_w[g]), .mdro(mdro_w[g]), .ryi(ryi_w[g]),
      .zi(zi_w[g]), .zlowo(zlowo_w[g]), .csigno(csign_w[g]), .gra(gra_w[g]),
      .grb(grb_w[g]), .grc(grc_w[g]), .rin(rin_w[g]), .rout(rout_w[g]),
      .baout(baout_w[g]), .ipo(ipo_w[g]), .opi(opi_w[g]), .con_in(conin_w[g]),
      .mem_read(mrd_w[g]), .mem_write(mwr_w[g]), .alu_op(alu_w[g]),
      .run(run_w[g]), .illegal(ill_w[g])
    );
  end

  function automatic vec_t obs(input int d);
    return {alu_w[d], ill_w[d], run_w[d], mwr_w[d], mrd_w[d], conin_w[d], opi_w[d],
            ipo_w[d], baout_w[d], rout_w[d], rin_w[d], grc_w[d], grb_w[d], gra_w[d],
            csign_w[d], zlowo_w[d], zi_w[d], ryi_w[d], mdro_w[d], mdri_w[d], mari_w[d],
            iri_w[d], pcinc_w[d], pco_w[d], pci_w[d]};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic void push(input int d, input vec_t v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endfunction

  // Expected cycle with run high; cycles past lim are counted but not queued.
  function automatic void put(input int d, inout int n, input int lim, input vec_t v);
    if (n < lim) push(d, v | M_RUN);
    n++;
  endfunction

  function automatic vec_t alu_m(input logic [4:0] op);
    case (op)
      5'd4:        return vec_t'(1) << 24;
      5'd5, 5'd13: return vec_t'(2) << 24;
      5'd6, 5'd14: return vec_t'(3) << 24;
      default:     return vec_t'(0);
    endcase
  endfunction

  function automatic bit is_def(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14,
                      5'd18, 5'd22, 5'd23, 5'd26, 5'd27};
  endfunction

  // Reference: the per-cycle strobe list of one whole instruction.
  function automatic int model(input int d, input logic [4:0] op, input logic cff, input int lim);
    int n = 0;
    int lat = lat_of(d);
    put(d, n, lim, M_PCO | M_MARI | M_PCINC);
    for (int i = 0; i < lat; i++) put(d, n, lim, M_MRD | ((i == lat - 1) ? M_MDRI : vec_t'(0)));
    put(d, n, lim, M_MDRO | M_IRI);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        put(d, n, lim, M_GRB | M_ROUT | M_RYI);
        put(d, n, lim, M_GRC | M_ROUT | M_ZI | alu_m(op));
        put(d, n, lim, M_ZLOWO | M_GRA | M_RIN);
      end
      5'd12, 5'd13, 5'd14: begin
        put(d, n, lim, M_GRB | M_ROUT | M_RYI);
        put(d, n, lim, M_CSIGN | M_ZI | alu_m(op));
        put(d, n, lim, M_ZLOWO | M_GRA | M_RIN);
      end
      5'd1, 5'd0, 5'd2: begin
        put(d, n, lim, M_GRB | M_BAOUT | M_RYI);
        put(d, n, lim, M_CSIGN | M_ZI);
        if (op == 5'd1) put(d, n, lim, M_ZLOWO | M_GRA | M_RIN);
        else            put(d, n, lim, M_ZLOWO | M_MARI);
        if (op == 5'd0) begin
          for (int i = 0; i < lat; i++) put(d, n, lim, M_MRD | ((i == lat - 1) ? M_MDRI : vec_t'(0)));
          put(d, n, lim, M_MDRO | M_GRA | M_RIN);
        end else if (op == 5'd2) begin
          put(d, n, lim, M_GRA | M_ROUT | M_MDRI);
          for (int i = 0; i < lat; i++) put(d, n, lim, M_MWR);
        end
      end
      5'd18: begin
        put(d, n, lim, M_GRA | M_ROUT | M_CONIN);
        put(d, n, lim, M_PCO | M_RYI);
        put(d, n, lim, M_CSIGN | M_ZI);
        put(d, n, lim, M_ZLOWO | (cff ? M_PCI : vec_t'(0)));
      end
      5'd22: put(d, n, lim, M_IPO | M_GRA | M_RIN);
      5'd23: put(d, n, lim, M_GRA | M_ROUT | M_OPI);
      5'd26, 5'd27: ;
      default: put(d, n, lim, M_ILL);
    endcase
    return n;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  function automatic logic [4:0] pick_op();
    logic [4:0] op;
    if ($urandom_range(0, 9) == 0) begin
      do op = 5'($urandom_range(0, 31)); while (is_def(op));
    end else begin
      op = ops[$urandom_range(0, 13)];
    end
    return op;
  endfunction

  // Issue one instruction word; stop (if requested) is held only during T0.
  task automatic run_word(input int d, input logic [31:0] w, input logic cff,
                          input logic stp, input int lim);
    int n;
    ir_r[d]   = w;
    cff_r[d]  = cff;
    stop_r[d] = stp;
    n = model(d, w[31:27], cff, lim);
    if (lim < n) n = lim;
    repeat (n) begin
      @(posedge clock); #1;
      stop_r[d] = 1'b0;
    end
  endtask

  task automatic halt_cycles(input int d, input int n);
    for (int i = 0; i < n; i++) push(d, vec_t'(0));
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic clear_pulse(input int cyc);
    for (int d = 0; d < 2; d++)
      if (chk[d]) for (int i = 0; i < cyc; i++) push(d, M_RUN);
    clear = 1'b1;
    repeat (cyc) @(posedge clock);
    #1 clear = 1'b0;
  endtask

  task automatic prog(input int d);
    if (d == 0) begin
      run_word(0, 32'h1811_0000, 1'b0, 1'b0, 1000);
      run_word(0, mk(5'd18), 1'b0, 1'b0, 1000);
      run_word(0, mk(5'd18), 1'b1, 1'b0, 1000);
      run_word(0, mk(5'd31), 1'b0, 1'b0, 1000);
      run_word(0, mk(5'd26), 1'b0, 1'b0, 1000);
      run_word(0, mk(5'd22), 1'b0, 1'b0, 1000);
      run_word(0, mk(5'd23), 1'b0, 1'b0, 1000);
    end else begin
      run_word(1, mk(5'd0), 1'b0, 1'b0, 1000);
      run_word(1, mk(5'd2), 1'b0, 1'b0, 1000);
      run_word(1, mk(5'd1), 1'b0, 1'b0, 1000);
      run_word(1, mk(5'd12), 1'b0, 1'b0, 1000);
    end
    for (int i = 0; i < 30; i++)
      run_word(d, mk(pick_op()), 1'($urandom_range(0, 1)), 1'b0, 1000);
    if (d == 1) begin
      run_word(1, mk(5'd3), 1'b0, 1'b1, 1000);
      halt_cycles(1, 5);
    end
    chk[d] = 1'b0;
  endtask

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (chk[d]) begin
        vec_t a, e;
        int sz;
        a = obs(d);
        sz = (d == 0) ? q0.size() : q1.size();
        vectors++;
        if (sz == 0) begin
          fails++;
          $display("FAIL dut%0d underrun: got %h with nothing expected", d, a);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL dut%0d vector %0d @%0t: got %h required %h", d, vectors, $time, a, e);
          end
        end
      end
    end
  end

  initial begin
    ir_r[0] = '0; ir_r[1] = '0; cff_r = '0; stop_r = '0; chk = '0;
    @(posedge clock); #1;
    chk = 2'b11;
    clear_pulse(2);
    fork
      prog(0);
      prog(1);
    join
    chk = 2'b01;
    clear_pulse(2);
    run_word(0, mk(5'd27), 1'b0, 1'b0, 1000);
    halt_cycles(0, 20);
    clear_pulse(2);
    run_word(0, mk(5'd2), 1'b0, 1'b0, 6);
    clear_pulse(2);
    run_word(0, 32'h1811_0000, 1'b0, 1'b0, 1000);
    chk = 2'b00;
    @(negedge clock);
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d expectations unconsumed, required 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
